tc_input_arbiter: RTL and testbench

//  Round-robin arbiter that shares TinyComp's single input port (InData/InRdy/InStrobe) between
//  N_SRC independent producers. One word is captured from the winning source into a holding

---
 rtl/tc_input_arbiter.sv | 70 +++++++
 tb/tb_tc_input_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tc_input_arbiter.sv
// tc_input_arbiter: round-robin arbiter sharing TinyComp's input port (Ph0 clock, Reset, src_valid/src_data/src_enable/src_ready sources, InData/InRdy/InStrobe to TinyComp, underrun_cnt)
module tc_input_arbiter #(
    parameter int N_SRC = 4,
    parameter int DW    = 24,
    parameter int SRCW  = 3,
    parameter int UCW   = 16
) (
    input  logic                Ph0,
    input  logic                Reset,
    input  logic [N_SRC-1:0]    src_valid,
    input  logic [N_SRC*DW-1:0] src_data,
    output logic [N_SRC-1:0]    src_ready,
    input  logic [N_SRC-1:0]    src_enable,
    output logic [31:0]         InData,
    output logic                InRdy,
    input  logic                InStrobe,
    output logic [UCW-1:0]      underrun_cnt
);
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] rot;
    logic [SRCW-1:0]  rr_ptr;
    logic [SRCW-1:0]  win;
    logic [SRCW-1:0]  hold_src;
    logic [DW-1:0]    hold_data;
    logic [DW-1:0]    pay;
    logic             hold_vld;
    logic             found;
    logic             load;
    assign elig = src_valid & src_enable;
    assign rot  = N_SRC'({elig, elig} >> rr_ptr);
    assign load = (~hold_vld | InStrobe) & found & ~Reset;
    assign InRdy = hold_vld;
    assign InData = hold_vld ? 32'({hold_src, hold_data}) : 32'h0;
    always_comb begin
        win = '0;
        found = 1'b0;
        pay = '0;
        src_ready = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win = SRCW'((int'(rr_ptr) + k) % N_SRC);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            pay = (win == SRCW'(i)) ? src_data[i*DW +: DW] : pay;
            src_ready[i] = load && (win == SRCW'(i));
        end
    end
    always_ff @(posedge Ph0) begin
        if (Reset) begin
            hold_vld     <= 1'b0;
            hold_data    <= '0;
            hold_src     <= '0;
            rr_ptr       <= '0;
            underrun_cnt <= '0;
        end else begin
            if (load) begin
                hold_data <= pay;
                hold_src  <= win;
                hold_vld  <= 1'b1;
                rr_ptr    <= (win == SRCW'(N_SRC - 1)) ? '0 : win + 1'b1;
            end else if (hold_vld && InStrobe) begin
                hold_vld <= 1'b0;
            end
            if (!hold_vld && InStrobe && !(&underrun_cnt))
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tc_input_arbiter.sv
// tb_tc_input_arbiter: scoreboard bench for tc_input_arbiter with directed vectors
module tb_tc_input_arbiter;
    logic        Ph0 = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  src_valid = '0;
    logic [95:0] src_data = {24'h444444, 24'h333333, 24'h222222, 24'hABCDEF};
    logic [3:0]  src_ready;
    logic [3:0]  src_enable = 4'hF;
    logic [31:0] InData;
    logic        InRdy;
    logic        InStrobe = 1'b0;
    logic [15:0] underrun_cnt;
    logic [31:0] gq[$];
    logic [31:0] wq[$];
    int          n_pass = 0;
    int          n_tot = 0;
    tc_input_arbiter #(.N_SRC(4), .DW(24), .SRCW(3), .UCW(16)) dut (
        .Ph0(Ph0), .Reset(Reset), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .src_enable(src_enable), .InData(InData),
        .InRdy(InRdy), .InStrobe(InStrobe), .underrun_cnt(underrun_cnt)
    );
    always #5 Ph0 = ~Ph0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic step();
        @(posedge Ph0);
        #1;
    endtask
    task automatic do_reset();
        Reset = 1'b1;
        src_valid = '0;
        InStrobe = 1'b0;
        src_enable = 4'hF;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("rst_inrdy", 32'(InRdy), 32'h0);
        chk("rst_indata", InData, 32'h0);
        chk("rst_underrun", 32'(underrun_cnt), 32'h0);
        chk("rst_ready", 32'(src_ready), 32'h0);
    endtask
    always @(negedge Ph0) begin
        if (!Reset) begin
            if (src_ready != 0) begin
                if (gq.size() == 0) chk("grant_unexpected", 32'(src_ready), 32'h0);
                else chk("grant", 32'(src_ready), gq.pop_front());
            end
            if (InRdy && InStrobe) begin
                if (wq.size() == 0) chk("word_unexpected", InData, 32'hFFFFFFFF);
                else chk("word", InData, wq.pop_front());
            end
        end
    end
    initial begin
        do_reset();
        gq.push_back(32'h1);
        wq.push_back(32'h00ABCDEF);
        src_valid = 4'b0001;
        step();
        src_valid = '0;
        chk("t1_inrdy", 32'(InRdy), 32'h1);
        chk("t1_indata", InData, 32'h00ABCDEF);
        InStrobe = 1'b1;
        step();
        InStrobe = 1'b0;
        chk("t1_empty", 32'(InRdy), 32'h0);
        do_reset();
        gq = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
        wq = '{32'h00ABCDEF, 32'h01222222, 32'h02333333, 32'h03444444, 32'h00ABCDEF};
        src_valid = 4'hF;
        InStrobe = 1'b1;
        repeat (5) step();
        src_valid = '0;
        step();
        InStrobe = 1'b0;
        chk("t2_empty", 32'(InRdy), 32'h0);
        do_reset();
        gq.push_back(32'h4);
        src_valid = 4'b0100;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", InData, 32'h02333333);
            chk("t3_ready", 32'(src_ready), 32'h0);
            step();
        end
        src_valid = '0;
        wq.push_back(32'h02333333);
        InStrobe = 1'b1;
        step();
        InStrobe = 1'b0;
        do_reset();
        InStrobe = 1'b1;
        repeat (3) step();
        InStrobe = 1'b0;
        chk("t4_cnt3", 32'(underrun_cnt), 32'h3);
        chk("t4_inrdy", 32'(InRdy), 32'h0);
        chk("t4_indata", InData, 32'h0);
        InStrobe = 1'b1;
        repeat (65531) step();
        chk("t4_fffe", 32'(underrun_cnt), 32'hFFFE);
        repeat (3) step();
        InStrobe = 1'b0;
        chk("t4_sat", 32'(underrun_cnt), 32'hFFFF);
        do_reset();
        gq = '{32'h1, 32'h2, 32'h8, 32'h1};
        wq = '{32'h00ABCDEF, 32'h01222222, 32'h03444444, 32'h00ABCDEF};
        src_enable = 4'b1011;
        src_valid = 4'hF;
        InStrobe = 1'b1;
        repeat (4) step();
        src_valid = '0;
        step();
        InStrobe = 1'b0;
        src_enable = 4'hF;
        do_reset();
        gq.push_back(32'h2);
        src_valid = 4'b0010;
        step();
        chk("t6_full", InData, 32'h01222222);
        src_valid = 4'hF;
        InStrobe = 1'b1;
        Reset = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(src_ready), 32'h0);
        step();
        Reset = 1'b0;
        InStrobe = 1'b0;
        src_valid = '0;
        #1;
        chk("t6_inrdy", 32'(InRdy), 32'h0);
        chk("t6_indata", InData, 32'h0);
        chk("t6_ready", 32'(src_ready), 32'h0);
        gq.push_back(32'h1);
        src_valid = 4'hF;
        step();
        src_valid = '0;
        wq.push_back(32'h00ABCDEF);
        InStrobe = 1'b1;
        step();
        InStrobe = 1'b0;
        step();
        chk("gq_drained", 32'(gq.size()), 32'h0);
        chk("wq_drained", 32'(wq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
